// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one memory bus between fetch, load and store with
// load > store > fetch priority and a starvation promotion for fetch.
module memory_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  fetch_req_i,
  input  logic                  fetch_invalidate_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_valid_o,
  output logic [DATA_WIDTH-1:0] fetch_instr_o,
  input  logic                  load_req_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  output logic                  load_valid_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  input  logic                  store_req_i,
  input  logic [ADDR_WIDTH-1:0] store_addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [1:0]            store_width_i,
  output logic                  store_done_o,
  output logic                  bus_req_o,
  output logic                  bus_write_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [1:0]            bus_width_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_wdone_i
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ, WAIT_WRITE} state_t;
  typedef enum logic [1:0] {CH_FETCH, CH_LOAD, CH_STORE} chan_t;
  state_t state_q, state_d;
  chan_t cur_q, cur_d, winner;
  logic fetch_pend_q, fetch_pend_d, load_pend_q, load_pend_d, store_pend_q, store_pend_d;
  logic fetch_sup_q, fetch_sup_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d, load_addr_q, load_addr_d;
  logic [ADDR_WIDTH-1:0] store_addr_q, store_addr_d, bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] store_data_q, store_data_d, bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] fetch_instr_q, fetch_instr_d, load_data_q, load_data_d;
  logic [1:0] store_width_q, store_width_d, bus_width_q, bus_width_d;
  logic bus_write_q, bus_write_d;
  logic fetch_valid_q, fetch_valid_d, load_valid_q, load_valid_d, store_done_q, store_done_d;
  logic [SW-1:0] starve_q, starve_d;
  logic fetch_live, gnt, rd_done, wr_done, arb, promote;
  logic fetch_take, load_take, store_take;

  always_comb begin
    fetch_live = fetch_pend_q & ~fetch_invalidate_i;
    gnt        = (state_q == ISSUE) & bus_gnt_i;
    rd_done    = (state_q == WAIT_READ) & bus_rvalid_i;
    wr_done    = (state_q == WAIT_WRITE) & bus_wdone_i;
    arb        = ((state_q == IDLE) | rd_done | wr_done) & (fetch_live | load_pend_q | store_pend_q);
    promote    = fetch_live & (starve_q == SW'(STARVE_LIMIT));
    winner     = promote ? CH_FETCH : load_pend_q ? CH_LOAD : store_pend_q ? CH_STORE : CH_FETCH;
    state_d    = arb ? ISSUE : (rd_done | wr_done) ? IDLE :
                 gnt ? ((cur_q == CH_STORE) ? WAIT_WRITE : WAIT_READ) : state_q;
    cur_d       = arb ? winner : cur_q;
    bus_write_d = arb ? (winner == CH_STORE) : bus_write_q;
    bus_addr_d  = !arb ? bus_addr_q : (winner == CH_LOAD) ? load_addr_q :
                  (winner == CH_STORE) ? store_addr_q : fetch_addr_q;
    bus_wdata_d = !arb ? bus_wdata_q : (winner == CH_STORE) ? store_data_q : '0;
    bus_width_d = !arb ? bus_width_q : (winner == CH_STORE) ? store_width_q : 2'd2;
    // An invalidate frees the fetch slot, so a same-cycle request is taken
    fetch_take   = fetch_req_i & (~fetch_pend_q | fetch_invalidate_i);
    fetch_pend_d = fetch_take | (fetch_pend_q & ~fetch_invalidate_i &
                   ~(gnt & (cur_q == CH_FETCH) & ~fetch_sup_q));
    fetch_addr_d = fetch_take ? fetch_addr_i : fetch_addr_q;
    load_take    = load_req_i & ~load_pend_q;
    load_pend_d  = load_take | (load_pend_q & ~(gnt & (cur_q == CH_LOAD)));
    load_addr_d  = load_take ? load_addr_i : load_addr_q;
    store_take    = store_req_i & ~store_pend_q;
    store_pend_d  = store_take | (store_pend_q & ~(gnt & (cur_q == CH_STORE)));
    store_addr_d  = store_take ? store_addr_i : store_addr_q;
    store_data_d  = store_take ? store_data_i : store_data_q;
    store_width_d = store_take ? store_width_i : store_width_q;
    // An in-flight fetch that is invalidated still runs on the bus but is not reported
    fetch_sup_d = arb ? 1'b0 : fetch_sup_q | (fetch_invalidate_i & (cur_q == CH_FETCH) &
                  ((state_q == ISSUE) | (state_q == WAIT_READ)));
    starve_d = !fetch_live ? '0 : !arb ? starve_q : (winner == CH_FETCH) ? '0 :
               (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    fetch_valid_d = rd_done & (cur_q == CH_FETCH) & ~fetch_sup_q & ~fetch_invalidate_i;
    fetch_instr_d = fetch_valid_d ? bus_rdata_i : fetch_instr_q;
    load_valid_d  = rd_done & (cur_q == CH_LOAD);
    load_data_d   = load_valid_d ? bus_rdata_i : load_data_q;
    store_done_d  = wr_done;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      cur_q         <= CH_FETCH;
      fetch_pend_q  <= 1'b0;
      load_pend_q   <= 1'b0;
      store_pend_q  <= 1'b0;
      fetch_sup_q   <= 1'b0;
      fetch_addr_q  <= '0;
      load_addr_q   <= '0;
      store_addr_q  <= '0;
      store_data_q  <= '0;
      store_width_q <= 2'd0;
      bus_write_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_width_q   <= 2'd2;
      starve_q      <= '0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      load_valid_q  <= 1'b0;
      load_data_q   <= '0;
      store_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      fetch_pend_q  <= fetch_pend_d;
      load_pend_q   <= load_pend_d;
      store_pend_q  <= store_pend_d;
      fetch_sup_q   <= fetch_sup_d;
      fetch_addr_q  <= fetch_addr_d;
      load_addr_q   <= load_addr_d;
      store_addr_q  <= store_addr_d;
      store_data_q  <= store_data_d;
      store_width_q <= store_width_d;
      bus_write_q   <= bus_write_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_width_q   <= bus_width_d;
      starve_q      <= starve_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      load_valid_q  <= load_valid_d;
      load_data_q   <= load_data_d;
      store_done_q  <= store_done_d;
    end
  end

  assign bus_req_o     = (state_q == ISSUE);
  assign bus_write_o   = bus_write_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign bus_width_o   = bus_width_q;
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_instr_o = fetch_instr_q;
  assign load_valid_o  = load_valid_q;
  assign load_data_o   = load_data_q;
  assign store_done_o  = store_done_q;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the arbiter.
module tb_memory_bus_arbiter;
  localparam int LIM = 8;
  localparam int F = 0, L = 1, S = 2;
  logic clk_i = 1'b0;
  logic rst_n_i;
  logic fetch_req_i, fetch_invalidate_i, load_req_i, store_req_i;
  logic [31:0] fetch_addr_i, load_addr_i, store_addr_i, store_data_i, bus_rdata_i;
  logic [1:0] store_width_i;
  logic bus_gnt_i, bus_rvalid_i, bus_wdone_i;
  logic fetch_valid_o, load_valid_o, store_done_o, bus_req_o, bus_write_o;
  logic [31:0] fetch_instr_o, load_data_o, bus_addr_o, bus_wdata_o;
  logic [1:0] bus_width_o;

  always #5 clk_i = ~clk_i;

  memory_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .fetch_req_i(fetch_req_i), .fetch_invalidate_i(fetch_invalidate_i), .fetch_addr_i(fetch_addr_i),
    .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o),
    .load_req_i(load_req_i), .load_addr_i(load_addr_i), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .store_req_i(store_req_i), .store_addr_i(store_addr_i), .store_data_i(store_data_i),
    .store_width_i(store_width_i), .store_done_o(store_done_o),
    .bus_req_o(bus_req_o), .bus_write_o(bus_write_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_width_o(bus_width_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_wdone_i(bus_wdone_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending requests per channel plus one in-flight transaction
  bit m_pend[3];
  logic [31:0] m_addr[3];
  logic [31:0] m_sdata;
  logic [1:0] m_swidth;
  bit m_active, m_granted, m_supp;
  int m_cur, m_starve;
  bit e_write, e_fv, e_lv, e_sd;
  logic [31:0] e_addr, e_wdata, e_fi, e_ld;
  logic [1:0] e_width;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0;
      m_addr[i] = 0;
    end
    m_sdata = 0; m_swidth = 0;
    m_active = 0; m_granted = 0; m_supp = 0; m_cur = F; m_starve = 0;
    e_write = 0; e_fv = 0; e_lv = 0; e_sd = 0;
    e_addr = 0; e_wdata = 0; e_fi = 0; e_ld = 0; e_width = 2'd2;
  endtask

  task automatic model_step();
    bit op[3];
    bit fpe, done, arb, gnt_now;
    bit clr[3];
    int win, nstarve;
    for (int i = 0; i < 3; i++) op[i] = m_pend[i];
    fpe = m_pend[F] && !fetch_invalidate_i;
    done = 0; e_fv = 0; e_lv = 0; e_sd = 0;
    if (m_active && m_granted) begin
      if (m_cur == S) begin
        if (bus_wdone_i) begin done = 1; e_sd = 1; end
      end else if (bus_rvalid_i) begin
        done = 1;
        if (m_cur == L) begin e_lv = 1; e_ld = bus_rdata_i; end
        else if (!m_supp && !fetch_invalidate_i) begin e_fv = 1; e_fi = bus_rdata_i; end
      end
    end
    gnt_now = m_active && !m_granted && bus_gnt_i;
    clr[F] = fetch_invalidate_i || (gnt_now && m_cur == F && !m_supp);
    clr[L] = gnt_now && m_cur == L;
    clr[S] = gnt_now && m_cur == S;
    arb = (!m_active || done) && (fpe || m_pend[L] || m_pend[S]);
    win = (fpe && m_starve == LIM) ? F : m_pend[L] ? L : m_pend[S] ? S : F;
    nstarve = !fpe ? 0 : !arb ? m_starve : (win == F) ? 0 : (m_starve < LIM ? m_starve + 1 : LIM);
    if (arb) begin
      m_active = 1; m_granted = 0; m_supp = 0; m_cur = win;
      e_write = (win == S);
      e_addr = m_addr[win];
      e_wdata = m_sdata;
      e_width = (win == S) ? m_swidth : 2'd2;
    end else if (done) begin
      m_active = 0;
    end else begin
      if (m_active && m_cur == F && fetch_invalidate_i) m_supp = 1;
      if (gnt_now) m_granted = 1;
    end
    m_starve = nstarve;
    for (int i = 0; i < 3; i++) if (clr[i]) m_pend[i] = 0;
    if (fetch_req_i && (!op[F] || fetch_invalidate_i)) begin m_pend[F] = 1; m_addr[F] = fetch_addr_i; end
    if (load_req_i && !op[L]) begin m_pend[L] = 1; m_addr[L] = load_addr_i; end
    if (store_req_i && !op[S]) begin
      m_pend[S] = 1; m_addr[S] = store_addr_i; m_sdata = store_data_i; m_swidth = store_width_i;
    end
  endtask

  task automatic compare();
    bit e_req;
    e_req = m_active && !m_granted;
    chk("bus_req", 32'(bus_req_o), 32'(e_req));
    if (e_req) begin
      chk("bus_write", 32'(bus_write_o), 32'(e_write));
      chk("bus_addr", bus_addr_o, e_addr);
      chk("bus_width", 32'(bus_width_o), 32'(e_width));
      if (e_write) chk("bus_wdata", bus_wdata_o, e_wdata);
    end
    chk("fetch_valid", 32'(fetch_valid_o), 32'(e_fv));
    if (e_fv) chk("fetch_instr", fetch_instr_o, e_fi);
    chk("load_valid", 32'(load_valid_o), 32'(e_lv));
    if (e_lv) chk("load_data", load_data_o, e_ld);
    chk("store_done", 32'(store_done_o), 32'(e_sd));
  endtask

  task automatic step();
    model_step();
    @(negedge clk_i);
    compare();
  endtask

  task automatic idle_inputs();
    fetch_req_i = 0; fetch_invalidate_i = 0; load_req_i = 0; store_req_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_wdone_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(bus_req_o), 0);
    chk({tag, "_write"}, 32'(bus_write_o), 0);
    chk({tag, "_addr"}, bus_addr_o, 0);
    chk({tag, "_width"}, 32'(bus_width_o), 2);
    chk({tag, "_fv"}, 32'(fetch_valid_o), 0);
    chk({tag, "_lv"}, 32'(load_valid_o), 0);
    chk({tag, "_sd"}, 32'(store_done_o), 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next clock edge
  task automatic do_reset();
    idle_inputs();
    #2 rst_n_i = 0;
    #1 check_reset_outputs("rst");
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1;
  endtask

  int q_cyc[$];
  logic [31:0] q_addr[$];
  logic [1:0] store_w;
  bit store_wr;
  int n_done, nf, loads1, loads2, n_lv;
  bit armed, pulse_next;

  initial begin
    rst_n_i = 0;
    fetch_addr_i = 0; load_addr_i = 0; store_addr_i = 0; store_data_i = 0; store_width_i = 0;
    bus_rdata_i = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk_i);
    check_reset_outputs("init");
    rst_n_i = 1;

    // single load, 2-cycle request latency
    load_req_i = 1; load_addr_i = 32'h100; step(); load_req_i = 0;
    chk("load_lat1_req", 32'(bus_req_o), 0);
    step();
    chk("load_lat2_req", 32'(bus_req_o), 1);
    chk("load_lat2_addr", bus_addr_o, 32'h100);
    chk("load_lat2_write", 32'(bus_write_o), 0);
    bus_gnt_i = 1; step(); bus_gnt_i = 0;
    bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF; step(); bus_rvalid_i = 0;
    chk("load_resp_valid", 32'(load_valid_o), 1);
    chk("load_resp_data", load_data_o, 32'hDEADBEEF);
    step();
    chk("load_resp_pulse_end", 32'(load_valid_o), 0);

    // simultaneous pulses: load, store, fetch back to back
    do_reset();
    fetch_req_i = 1; fetch_addr_i = 32'h40;
    load_req_i = 1; load_addr_i = 32'h80;
    store_req_i = 1; store_addr_i = 32'hC0; store_data_i = 32'hA5; store_width_i = 2'd0;
    bus_gnt_i = 1; bus_rvalid_i = 1; bus_wdone_i = 1; bus_rdata_i = 32'h1234;
    step();
    fetch_req_i = 0; load_req_i = 0; store_req_i = 0;
    n_done = 0; store_w = 2'd3; store_wr = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (store_done_o) n_done++;
      if (bus_req_o) begin
        q_cyc.push_back(k);
        q_addr.push_back(bus_addr_o);
        if (bus_addr_o == 32'hC0) begin store_w = bus_width_o; store_wr = bus_write_o; end
      end
    end
    idle_inputs();
    chk("order_count", q_addr.size(), 3);
    if (q_addr.size() == 3) begin
      chk("order_first_load", q_addr[0], 32'h80);
      chk("order_second_store", q_addr[1], 32'hC0);
      chk("order_third_fetch", q_addr[2], 32'h40);
      chk("no_bubble_1", q_cyc[1] - q_cyc[0], 2);
      chk("no_bubble_2", q_cyc[2] - q_cyc[1], 2);
    end
    chk("store_byte_width", 32'(store_w), 0);
    chk("store_is_write", 32'(store_wr), 1);
    chk("store_done_once", n_done, 1);

    // starvation: load re-requested every transaction
    do_reset();
    fetch_addr_i = 32'h400; load_addr_i = 32'h500;
    fetch_req_i = 1; load_req_i = 1; bus_gnt_i = 1;
    step();
    nf = 0; loads1 = 0; loads2 = 0; armed = 0; pulse_next = 0;
    for (int i = 0; i < 300 && nf < 2; i++) begin
      fetch_req_i = pulse_next;
      pulse_next = 0;
      bus_rvalid_i = m_active && m_granted && m_pend[L];
      bus_rdata_i = $urandom;
      step();
      if (bus_req_o) begin
        if (bus_addr_o == 32'h400) nf++;
        else if (nf == 0) loads1++;
        else if (!armed) begin armed = 1; pulse_next = 1; end
        else loads2++;
      end
    end
    chk("starve_fetch_issues", nf, 2);
    chk("starve_losses_first", loads1, LIM);
    chk("starve_losses_after_reset", loads2, LIM);

    // invalidate while the fetch read is outstanding
    do_reset();
    fetch_req_i = 1; fetch_addr_i = 32'h180; step(); fetch_req_i = 0;
    step();
    chk("inv_issue_addr", bus_addr_o, 32'h180);
    bus_gnt_i = 1; step(); bus_gnt_i = 0;
    fetch_invalidate_i = 1; step(); fetch_invalidate_i = 0;
    bus_rvalid_i = 1; bus_rdata_i = 32'hCAFEF00D; step(); bus_rvalid_i = 0;
    chk("inv_suppressed", 32'(fetch_valid_o), 0);
    step();
    fetch_req_i = 1; fetch_addr_i = 32'h200; step(); fetch_req_i = 0;
    step();
    chk("refetch_req", 32'(bus_req_o), 1);
    chk("refetch_addr", bus_addr_o, 32'h200);
    bus_gnt_i = 1; step(); bus_gnt_i = 0;
    bus_rvalid_i = 1; bus_rdata_i = 32'h13579BDF; step(); bus_rvalid_i = 0;
    chk("refetch_valid", 32'(fetch_valid_o), 1);
    chk("refetch_instr", fetch_instr_o, 32'h13579BDF);

    // reset during WAIT_WRITE, late write completion ignored
    do_reset();
    store_req_i = 1; store_addr_i = 32'h600; store_data_i = 32'hFEEDFACE; store_width_i = 2'd1;
    step(); store_req_i = 0;
    step();
    chk("wr_issue_write", 32'(bus_write_o), 1);
    chk("wr_issue_width", 32'(bus_width_o), 1);
    bus_gnt_i = 1; step(); bus_gnt_i = 0;
    do_reset();
    bus_wdone_i = 1; step(); bus_wdone_i = 0;
    chk("late_wdone_ignored", 32'(store_done_o), 0);
    step();
    chk("late_wdone_ignored2", 32'(store_done_o), 0);

    // duplicate load while pending keeps the first address
    do_reset();
    load_req_i = 1; load_addr_i = 32'h100; step();
    load_addr_i = 32'h1FC; step(); load_req_i = 0;
    chk("dup_first_addr", bus_addr_o, 32'h100);
    bus_gnt_i = 1; step(); bus_gnt_i = 0;
    bus_rvalid_i = 1; bus_rdata_i = 32'h55; n_lv = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      bus_rvalid_i = 0;
      if (load_valid_o) n_lv++;
    end
    chk("dup_one_valid", n_lv, 1);

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      fetch_req_i = ($urandom_range(0, 4) == 0);
      fetch_addr_i = $urandom;
      fetch_invalidate_i = ($urandom_range(0, 15) == 0);
      load_req_i = ($urandom_range(0, 4) == 0);
      load_addr_i = $urandom;
      store_req_i = ($urandom_range(0, 4) == 0);
      store_addr_i = $urandom;
      store_data_i = $urandom;
      store_width_i = 2'($urandom_range(0, 2));
      bus_gnt_i = 1'($urandom_range(0, 1));
      bus_rvalid_i = ($urandom_range(0, 2) == 0);
      bus_wdone_i = ($urandom_range(0, 2) == 0);
      bus_rdata_i = $urandom;
      if ($urandom_range(0, 799) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
